// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//
// Multi-cycle multiply/divide unit with integrated HI/LO registers for the
// E stage of a 5-stage MIPS pipeline. It accepts one operation per handshake
// and computes the result at the accept edge into a pending register. It then
// holds that result for MUL_CYCLES or DIV_CYCLES cycles and commits it to
// HI/LO atomically. The hold models the latency of the real unit.
//
// Build option:
//   MD_MADD_EN  when defined, enables madd/maddu/msub/msubu (ops 7..10).
//               The product is added to or subtracted from {HI,LO}, with
//               {HI,LO} sampled at the commit edge.
//
// Parameters:
//   WIDTH       operand and HI/LO width
//   MUL_CYCLES  accept-to-commit latency of the multiply family (>= 1)
//   DIV_CYCLES  accept-to-commit latency of div/divu (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_valid  in   operation request from the E stage
//   in_op     in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi,
//                  7 madd, 8 maddu, 9 msub, 10 msubu, 11..15 reserved
//   in_src0   in   rs operand / dividend / mthi-mtlo data
//   in_src1   in   rt operand / divisor
//   flush     in   cancels an in-flight operation and blocks accepts
//   in_ready  out  unit is IDLE
//   busy      out  unit is BUSY
//   hi        out  HI register
//   lo        out  LO register
// -----------------------------------------------------------------------------
module md_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_src0,
   input  logic [WIDTH-1:0] in_src1,
   input  logic             flush,
   output logic             in_ready,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // The counter only ever holds LAT-1, so clog2 of the larger latency is enough.
   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef MD_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [2*WIDTH-1:0]   r_pend;      // {HI,LO} image computed at accept
`ifdef MD_MADD_EN
   logic                 r_pend_acc;  // pending value is a product to accumulate
   logic                 r_pend_sub;  // accumulate by subtraction
   logic                 w_is_acc;
   logic                 w_is_sub;
`endif

   // ------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------
   logic [15:0] w_op_legal;
   logic        w_is_div;
   logic        w_is_mt;
   logic        w_signed;
   logic        w_accept;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_op_legal
         if (gi >= 1 && gi <= 6) begin : g_base
            assign w_op_legal[gi] = 1'b1;
         end else if (gi >= 7 && gi <= 10) begin : g_madd
            assign w_op_legal[gi] = MADD_EN;
         end else begin : g_reserved
            assign w_op_legal[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      w_is_div = 1'b0;
      w_is_mt  = 1'b0;
      w_signed = 1'b0;
      case (in_op)
         OP_MULT, OP_MADD, OP_MSUB: w_signed = 1'b1;
         OP_DIV: begin
            w_is_div = 1'b1;
            w_signed = 1'b1;
         end
         OP_DIVU:          w_is_div = 1'b1;
         OP_MTLO, OP_MTHI: w_is_mt  = 1'b1;
         default: ;
      endcase
   end

`ifdef MD_MADD_EN
   assign w_is_acc = (in_op == OP_MADD) || (in_op == OP_MADDU) ||
                     (in_op == OP_MSUB) || (in_op == OP_MSUBU);
   assign w_is_sub = (in_op == OP_MSUB) || (in_op == OP_MSUBU);
`endif

   // flush blocks accepts even in IDLE; reserved ops never handshake.
   assign w_accept = in_valid && (r_state == S_IDLE) && !flush && w_op_legal[in_op];

   // ------------------------------------------------------------------
   // Multiplier: sign- or zero-extend to 2*WIDTH so that a single
   // unsigned multiplier yields the correct low 2*WIDTH bits either way.
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_op0_ext;
   logic [2*WIDTH-1:0] w_op1_ext;
   logic [2*WIDTH-1:0] w_prod;

   assign w_op0_ext = {{WIDTH{w_signed & in_src0[WIDTH-1]}}, in_src0};
   assign w_op1_ext = {{WIDTH{w_signed & in_src1[WIDTH-1]}}, in_src1};
   assign w_prod    = w_op0_ext * w_op1_ext;

   // ------------------------------------------------------------------
   // Divider: signed division is done on magnitudes with one unsigned
   // divider, then signs are restored. This gives truncation toward zero,
   // a remainder with the dividend's sign, and MIN / -1 = MIN rem 0
   // without relying on signed-overflow behaviour of the / operator.
   // ------------------------------------------------------------------
   logic             w_neg0;
   logic             w_neg1;
   logic [WIDTH-1:0] w_mag0;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_den;
   logic [WIDTH-1:0] w_uq;
   logic [WIDTH-1:0] w_ur;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   assign w_neg0 = w_signed & in_src0[WIDTH-1];
   assign w_neg1 = w_signed & in_src1[WIDTH-1];
   assign w_mag0 = w_neg0 ? (-in_src0) : in_src0;
   assign w_mag1 = w_neg1 ? (-in_src1) : in_src1;
   // Keep the divider away from a zero denominator; that case is overridden below.
   assign w_den  = (in_src1 == '0) ? WIDTH'(1) : w_mag1;
   assign w_uq   = w_mag0 / w_den;
   assign w_ur   = w_mag0 % w_den;

   always_comb begin
      if (in_src1 == '0) begin
         w_quo = '1;
         w_rem = in_src0;
      end else begin
         w_quo = (w_neg0 ^ w_neg1) ? (-w_uq) : w_uq;
         w_rem = w_neg0 ? (-w_ur) : w_ur;
      end
   end

   // ------------------------------------------------------------------
   // Commit value. Accumulating ops read {HI,LO} at the commit edge, so an
   // mthi/mtlo cannot slip in between (the unit is busy), but the value
   // used is whatever HI/LO hold when the latency expires.
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_commit;

`ifdef MD_MADD_EN
   always_comb begin
      w_commit = r_pend;
      if (r_pend_acc) begin
         w_commit = r_pend_sub ? ({r_hi, r_lo} - r_pend) : ({r_hi, r_lo} + r_pend);
      end
   end
`else
   assign w_commit = r_pend;
`endif

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            // mthi/mtlo complete in the accept edge and never go busy.
            if (w_accept && !w_is_mt) begin
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush || (r_cnt == '0)) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign in_ready = (r_state == S_IDLE);
   assign busy     = (r_state == S_BUSY);

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_pend <= '0;
         r_cnt  <= '0;
`ifdef MD_MADD_EN
         r_pend_acc <= 1'b0;
         r_pend_sub <= 1'b0;
`endif
      end else if (r_state == S_IDLE) begin
         if (w_accept) begin
            if (in_op == OP_MTLO) begin
               r_lo <= in_src0;
            end else if (in_op == OP_MTHI) begin
               r_hi <= in_src0;
            end else begin
               r_pend <= w_is_div ? {w_rem, w_quo} : w_prod;
               r_cnt  <= w_is_div ? DIV_LOAD : MUL_LOAD;
`ifdef MD_MADD_EN
               r_pend_acc <= w_is_acc;
               r_pend_sub <= w_is_sub;
`endif
            end
         end
      end else if (!flush) begin
         // Flush in BUSY simply returns to IDLE; the pending value is dropped.
         if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_commit;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit
//
// Directed plus randomized bench for md_unit. A behavioural model of HI/LO
// (plain 64-bit arithmetic and integer division) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_md_unit;

   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;

`ifdef MD_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [3:0]   in_op;
   logic [W-1:0] in_src0;
   logic [W-1:0] in_src1;
   logic         flush;
   logic         in_ready;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   md_unit #(
      .WIDTH     (W),
      .MUL_CYCLES(ML),
      .DIV_CYCLES(DL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_valid(in_valid),
      .in_op   (in_op),
      .in_src0 (in_src0),
      .in_src1 (in_src1),
      .flush   (flush),
      .in_ready(in_ready),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; sampling and driving happen here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts cycles with busy high, bounded so a stuck unit cannot hang the run.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] f_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int     ia;
      int     ib;
      longint la;
      longint lb;
      if (sgn) begin
         ia = a;
         ib = b;
         la = ia;
         lb = ib;
         return 64'(la * lb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic m_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
      int ia;
      int ib;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         ia = a;
         ib = b;
         q  = ia / ib;
         r  = ia % ib;
      end
   endtask

   // Issue one request for a single edge, update the model, and check latency,
   // handshake state and HI/LO.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          lat;
      int          n;
      logic        legal;
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      lat   = 0;
      legal = (op >= 1 && op <= 6) || (MADD && op >= 7 && op <= 10);
      in_valid = 1'b1;
      in_op    = op;
      in_src0  = a;
      in_src1  = b;
      tick();
      in_valid = 1'b0;
      if (legal) begin
         case (op)
            4'd1, 4'd2: begin
               {m_hi, m_lo} = f_prod(op == 4'd1, a, b);
               lat = ML;
            end
            4'd3, 4'd4: begin
               m_div(op == 4'd3, a, b, q, r);
               m_hi = r;
               m_lo = q;
               lat  = DL;
            end
            4'd5: m_lo = a;
            4'd6: m_hi = a;
            4'd7, 4'd8: begin
               p = f_prod(op == 4'd7, a, b);
               {m_hi, m_lo} = {m_hi, m_lo} + p;
               lat = ML;
            end
            default: begin
               p = f_prod(op == 4'd9, a, b);
               {m_hi, m_lo} = {m_hi, m_lo} - p;
               lat = ML;
            end
         endcase
      end
      if (lat > 0) begin
         wait_busy(n);
         chk({tag, "_busycycles"}, 64'(n), 64'(lat));
      end else begin
         chk({tag, "_busy"}, 64'(busy), 64'd0);
      end
      chk({tag, "_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
      chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
      $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          n;
      logic [31:0] q;
      logic [31:0] r;
      logic [3:0]  op;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_op    = 4'd0;
      in_src0  = '0;
      in_src1  = '0;
      flush    = 1'b0;
      m_hi     = '0;
      m_lo     = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      // mult / multu
      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
      chk("mult_hi_lit", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo_lit", 64'(lo), 64'hFFFF_FFFA);
      run_op(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
      chk("multu_hi_lit", 64'(hi), 64'h0000_0002);
      chk("multu_lo_lit", 64'(lo), 64'hFFFF_FFFA);

      // div / divu edge cases
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
      chk("div_neg_lo_lit", 64'(lo), 64'hFFFF_FFFD);
      chk("div_neg_hi_lit", 64'(hi), 64'hFFFF_FFFF);
      run_op(4'd4, 32'd7, 32'd0, "divu_zero");
      chk("divu_zero_lo_lit", 64'(lo), 64'hFFFF_FFFF);
      chk("divu_zero_hi_lit", 64'(hi), 64'd7);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      chk("div_ovf_lo_lit", 64'(lo), 64'h8000_0000);
      chk("div_ovf_hi_lit", 64'(hi), 64'd0);

      // mthi then mtlo on consecutive edges
      in_valid = 1'b1;
      in_op    = 4'd6;
      in_src0  = 32'h1234_5678;
      tick();
      m_hi = 32'h1234_5678;
      chk("mthi_hi", 64'(hi), 64'h1234_5678);
      chk("mthi_busy", 64'(busy), 64'd0);
      in_op   = 4'd5;
      in_src0 = 32'h9ABC_DEF0;
      tick();
      m_lo = 32'h9ABC_DEF0;
      in_valid = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
      chk("mtlo_hi", 64'(hi), 64'h1234_5678);
      chk("mtlo_busy", 64'(busy), 64'd0);

      // Request held through BUSY: mult accepted only when in_ready returns
      in_valid = 1'b1;
      in_op    = 4'd3;
      in_src0  = 32'd100;
      in_src1  = 32'd7;
      tick();
      m_div(1'b1, 32'd100, 32'd7, q, r);
      m_hi    = r;
      m_lo    = q;
      in_op   = 4'd1;
      in_src0 = 32'hFFFF_FFF0;
      in_src1 = 32'h0000_1234;
      wait_busy(n);
      chk("held_div_busycycles", 64'(n), 64'(DL));
      chk("held_div_ready", 64'(in_ready), 64'd1);
      chk("held_div_hi", 64'(hi), 64'(m_hi));
      chk("held_div_lo", 64'(lo), 64'(m_lo));
      tick();
      in_valid = 1'b0;
      chk("held_mult_accepted", 64'(busy), 64'd1);
      {m_hi, m_lo} = f_prod(1'b1, 32'hFFFF_FFF0, 32'h0000_1234);
      wait_busy(n);
      chk("held_mult_busycycles", 64'(n), 64'(ML));
      chk("held_mult_hi", 64'(hi), 64'(m_hi));
      chk("held_mult_lo", 64'(lo), 64'(m_lo));

      // Flush on the 4th busy cycle of a divide
      in_valid = 1'b1;
      in_op    = 4'd3;
      in_src0  = 32'd12345;
      in_src1  = 32'd17;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("flush_prebusy", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      chk("flush_hi", 64'(hi), 64'(m_hi));
      chk("flush_lo", 64'(lo), 64'(m_lo));
      repeat (12) tick();
      chk("flush_late_hi", 64'(hi), 64'(m_hi));
      chk("flush_late_lo", 64'(lo), 64'(m_lo));

      // Flush with a valid mult in IDLE: nothing accepted
      in_valid = 1'b1;
      in_op    = 4'd1;
      in_src0  = 32'd9;
      in_src1  = 32'd9;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_idle_busy", 64'(busy), 64'd0);
      repeat (ML + 2) tick();
      chk("flush_idle_hi", 64'(hi), 64'(m_hi));
      chk("flush_idle_lo", 64'(lo), 64'(m_lo));

      // Reset in the middle of a divide
      in_valid = 1'b1;
      in_op    = 4'd4;
      in_src0  = 32'd1000;
      in_src1  = 32'd3;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ready", 64'(in_ready), 64'd1);
      repeat (DL + 2) tick();
      chk("midrst_late_hi", 64'(hi), 64'd0);
      chk("midrst_late_lo", 64'(lo), 64'd0);

      // Multiply-accumulate family
`ifdef MD_MADD_EN
      run_op(4'd6, 32'd0, 32'd0, "macc_mthi");
      run_op(4'd5, 32'hFFFF_FFFF, 32'd0, "macc_mtlo");
      run_op(4'd8, 32'd1, 32'd1, "maddu");
      chk("maddu_hi_lit", 64'(hi), 64'd1);
      chk("maddu_lo_lit", 64'(lo), 64'd0);
      run_op(4'd9, 32'd2, 32'd3, "msub");
      chk("msub_hi_lit", 64'(hi), 64'd0);
      chk("msub_lo_lit", 64'(lo), 64'hFFFF_FFFA);
`else
      run_op(4'd6, 32'hCAFE_0001, 32'd0, "pre_madd_mthi");
      run_op(4'd7, 32'd5, 32'd6, "madd_reserved");
      chk("madd_reserved_hi_lit", 64'(hi), 64'hCAFE_0001);
`endif
      run_op(4'd11, 32'd5, 32'd6, "reserved11");
      run_op(4'd0, 32'd5, 32'd6, "noop0");

      // Randomized sequence against the model
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         run_op(op, pick_operand(), pick_operand(), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts one operation per handshake, holds the result internally for a configurable number of cycles, then commits it atomically to HI/LO. It adds independent multiply and divide latencies, defined divide-by-zero results, a flush that cancels an in-flight operation, and optional multiply-accumulate.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `MUL_CYCLES`, 5, cycles from accept to HI/LO commit for mult/multu (and madd family); must be ≥ 1
- `DIV_CYCLES`, 10, cycles from accept to HI/LO commit for div/divu; must be ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  operation request from E stage
- `in_op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 reserved
- `in_src0`  in  WIDTH  rs operand; dividend; mthi/mtlo data
- `in_src1`  in  WIDTH  rt operand; divisor
- `flush`  in  1  cancel in-flight operation; block any accept this cycle
- `in_ready`  out  1  high when state is IDLE
- `busy`  out  1  high when state is BUSY; the hazard unit stalls mfhi/mflo and any md instruction in D while `busy` or while an md op is valid in E
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE and BUSY. After reset: IDLE, `hi`=`lo`=0, `busy`=0, `in_ready`=1.
- An operation is accepted on an edge where `in_valid` && `in_ready` && !`flush` && `in_op` ∈ {1..10}. Ops 0 and 11–15 are no-ops and are never accepted.
- mtlo/mthi: `lo` (resp. `hi`) ← `in_src0` at the accept edge. The state stays IDLE and the other register is unchanged.
- mult/multu: {HI,LO} ← 2·WIDTH-bit product, signed or unsigned.
- div/divu: LO ← quotient, HI ← remainder. The signed quotient truncates toward zero and the remainder takes the sign of the dividend. Signed MIN / −1: LO=MIN, HI=0.
- Divisor zero (div or divu): LO ← all ones, HI ← `in_src0`.
- Result computation: operands and the computed result are captured at the accept edge into pending registers. The state → BUSY and the counter ← LAT−1, where LAT = MUL_CYCLES or DIV_CYCLES.
- In BUSY, on each edge:
  - If `flush`: → IDLE; HI/LO unchanged; pending result discarded.
  - Else if counter==0: HI/LO ← pending result; → IDLE.
  - Else: counter decrements.
- `in_valid` while BUSY is ignored. The requester holds the request; it is not queued.
- `reset` at any edge overrides everything, including mid-operation: → IDLE, HI=LO=0.

## Timing
- Accept at edge E0. `busy`=1 in the cycles after E0, through edge E0+LAT. HI/LO show the new value after edge E0+LAT, when `busy` drops and `in_ready` rises in the same cycle.
- The earliest next accept is at edge E0+LAT+1.
- mthi/mtlo are visible on `hi`/`lo` in the cycle after the accept edge, with zero busy cycles.
- `in_ready` and `busy` are complementary, both registered-state decodes, with no combinational path from inputs.
- `hi`/`lo` are direct register outputs.

## Configuration
- `MD_MADD_EN` defined:
  - Ops 7–10 are accepted.
  - madd/maddu: {HI,LO} ← {HI,LO} + product.
  - msub/msubu: {HI,LO} ← {HI,LO} − product.
  - Arithmetic is 2·WIDTH-bit wrap-around, signed/unsigned product per op.
  - The {HI,LO} value is sampled at the commit edge, not the accept edge, with latency MUL_CYCLES.
- `MD_MADD_EN` undefined: ops 7–10 are treated as reserved (never accepted, no state change, `in_ready` stays 1).

## Test plan
- Reset, then mult of 0xFFFFFFFE by 3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div of 0xFFFFFFF9 (−7) by 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu of 7 by 0 → LO=0xFFFFFFFF, HI=7. div of 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → both visible one cycle after each accept, `busy` never asserted. A mult request held during BUSY is accepted only on the cycle `in_ready` returns.
- Start div, assert `flush` on the 4th busy cycle → IDLE the next cycle, HI/LO keep their prior values. `flush` together with `in_valid`=1 mult in IDLE → nothing accepted.
- Assert `reset` mid-divide → the next cycle shows HI=LO=0, `busy`=0, `in_ready`=1, and no late commit.
- With `MD_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu 1×1 → HI=1, LO=0; then msub 2×3 → {HI,LO}=0x00000000_FFFFFFFA. Without `MD_MADD_EN`: op 7 leaves HI/LO and `in_ready` unchanged.
